// File: rtl/intc.sv
// intc: single-level interrupt controller.
//
// Latches per-source requests into PENDING, masks them with ENABLE and picks
// the lowest enabled pending index. The winner is presented to the CPU as a
// registered request plus ID (index + 1). Software takes the winner with a
// CLAIM read and releases it with a COMPLETE write of the same ID.
//
// Optional feature macro: INTC_EDGE_EN. When defined, sources are edge
// sensitive (one pending event per rising edge). When undefined, sources are
// level sensitive (pending re-set on every cycle the source is high).
//
// Ports:
//   clk_i      sole clock
//   rst_i      synchronous active-high reset
//   req_i      bus access valid this cycle
//   we_i       1 = write, 0 = read
//   addr_i     register byte address (only [7:0] decoded)
//   wdata_i    write data
//   rdata_o    combinational read data
//   irq_src_i  raw source requests, bit i = source i
//   irq_o      registered interrupt request
//   irq_id_o   registered ID of request / in-service source, 0 = none
//
// Register map: 0x00 PENDING (W1C), 0x04 ENABLE, 0x08 CLAIM,
//               0x0C COMPLETE (write-only), 0x10 RAW.
module intc #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_SRC    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic [NUM_SRC-1:0]    irq_src_i,
  output logic                  irq_o,
  output logic [4:0]            irq_id_o
);

  localparam logic [7:0] AddrPending  = 8'h00;
  localparam logic [7:0] AddrEnable   = 8'h04;
  localparam logic [7:0] AddrClaim    = 8'h08;
  localparam logic [7:0] AddrComplete = 8'h0C;
  localparam logic [7:0] AddrRaw      = 8'h10;

  typedef enum logic [0:0] {StIdle, StService} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [4:0]         svc_id_q, svc_id_d;
  logic               irq_q, irq_d;
  logic [4:0]         irq_id_q, irq_id_d;

  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] best_oh;
  logic [NUM_SRC-1:0] claim_oh;
  logic [NUM_SRC-1:0] w1c;
  logic [4:0]         best_id;
  logic [7:0]         bus_addr;
  logic               rd_en, wr_en, claim_rd, complete_wr;

  // Upper address bits are stripped by the bus decoder; upper data bits unused.
  logic unused_bits;
  assign unused_bits = ^{addr_i, wdata_i};

  assign bus_addr    = addr_i[7:0];
  assign rd_en       = req_i & ~we_i;
  assign wr_en       = req_i & we_i;
  assign claim_rd    = rd_en & (bus_addr == AddrClaim);
  assign complete_wr = wr_en & (bus_addr == AddrComplete);

`ifdef INTC_EDGE_EN
  logic [NUM_SRC-1:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= '0;
    else       prev_q <= irq_src_i;
  end

  assign set_vec = irq_src_i & ~prev_q;
`else
  assign set_vec = irq_src_i;
`endif

  assign active = pending_q & enable_q;

  // Fixed priority: scan downwards so the lowest active index is written last.
  always_comb begin
    best_id = '0;
    best_oh = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        best_id    = 5'(i + 1);
        best_oh    = '0;
        best_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    svc_id_d = svc_id_q;
    irq_d    = 1'b0;
    irq_id_d = '0;
    claim_oh = '0;
    unique case (state_q)
      StIdle: begin
        irq_d    = (best_id != 5'd0);
        irq_id_d = best_id;
        if (claim_rd && (best_id != 5'd0)) begin
          claim_oh = best_oh;
          svc_id_d = best_id;
          state_d  = StService;
        end
      end
      StService: begin
        irq_id_d = svc_id_q;
        if (complete_wr && (wdata_i[4:0] == svc_id_q)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Set is applied last so a new request beats both W1C and claim-clear.
  assign w1c       = (wr_en && bus_addr == AddrPending) ? wdata_i[NUM_SRC-1:0] : '0;
  assign pending_d = (pending_q & ~w1c & ~claim_oh) | set_vec;
  assign enable_d  = (wr_en && bus_addr == AddrEnable) ? wdata_i[NUM_SRC-1:0] : enable_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pending_q <= '0;
      enable_q  <= '0;
      svc_id_q  <= '0;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      svc_id_q  <= svc_id_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (req_i) begin
      case (bus_addr)
        AddrPending: rdata_o[NUM_SRC-1:0] = pending_q;
        AddrEnable:  rdata_o[NUM_SRC-1:0] = enable_q;
        AddrClaim:   rdata_o[4:0] = (state_q == StIdle) ? best_id : svc_id_q;
        AddrRaw:     rdata_o[NUM_SRC-1:0] = irq_src_i;
        default:     rdata_o = '0;
      endcase
    end
  end

  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;

endmodule

// File: tb/tb_intc.sv
// Self-checking bench for intc: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a
// behavioural model of the register/claim rules.
module tb_intc;

  localparam int unsigned NSRC = 8;
  localparam int unsigned MASK = (1 << NSRC) - 1;
`ifdef INTC_EDGE_EN
  localparam bit EdgeMode = 1'b1;
`else
  localparam bit EdgeMode = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            req;
  logic            we;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata_o;
  logic [NSRC-1:0] src;
  logic            irq_o;
  logic [4:0]      irq_id_o;

  intc #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .NUM_SRC   (NSRC)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rdata_o  (rdata_o),
    .irq_src_i(src),
    .irq_o    (irq_o),
    .irq_id_o (irq_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending/enable as integers, service as a busy flag.
  int unsigned m_pend = 0, m_en = 0, m_prev = 0, m_svc = 0, m_id = 0;
  bit          m_busy = 0, m_irq = 0;

  function automatic int unsigned m_best();
    for (int i = 0; i < NSRC; i++) if (((m_pend & m_en) >> i) & 1) return i + 1;
    return 0;
  endfunction

  function automatic int unsigned exp_rdata();
    if (!req) return 0;
    case (addr[7:0])
      8'h00:   return m_pend;
      8'h04:   return m_en;
      8'h08:   return m_busy ? m_svc : m_best();
      8'h10:   return 32'(src) & MASK;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int unsigned s, set_v, b, p;
    if (rst) begin
      m_pend = 0; m_en = 0; m_prev = 0; m_svc = 0; m_busy = 0; m_irq = 0; m_id = 0;
      return;
    end
    s     = 32'(src);
    set_v = EdgeMode ? (s & ~m_prev) : s;
    b     = m_best();
    p     = m_pend;
    if (req && we && addr[7:0] == 8'h00) p = p & ~wdata;
    m_irq = !m_busy && (b != 0);
    m_id  = m_busy ? m_svc : b;
    if (!m_busy && req && !we && addr[7:0] == 8'h08 && b != 0) begin
      p      = p & ~(32'd1 << (b - 1));
      m_svc  = b;
      m_busy = 1'b1;
    end else if (m_busy && req && we && addr[7:0] == 8'h0C && 32'(wdata[4:0]) == m_svc) begin
      m_busy = 1'b0;
    end
    if (req && we && addr[7:0] == 8'h04) m_en = wdata & MASK;
    m_pend = (p | set_v) & MASK;
    m_prev = s;
  endtask

  always @(posedge clk) model_step();

  // Compare process: registered outputs every cycle, read data on reads.
  always @(negedge clk) begin
    if (chk_en) begin
      check("irq_o", 32'(irq_o), 32'(m_irq));
      check("irq_id_o", 32'(irq_id_o), m_id);
      if (req && !we) check("rdata_o", rdata_o, exp_rdata());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    req = 1'b1; we = 1'b0; addr = a;
    #1;
    check(name, rdata_o, exp);
    req = 1'b0; addr = '0;
  endtask

  task automatic claim(input string name, input logic [31:0] exp);
    req = 1'b1; we = 1'b0; addr = 32'h08;
    #1;
    check(name, rdata_o, exp);
    tick();
    req = 1'b0; addr = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  logic [31:0] addr_tbl [8];

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; src = '0;
    addr_tbl[0] = 32'h00; addr_tbl[1] = 32'h04; addr_tbl[2] = 32'h08; addr_tbl[3] = 32'h0C;
    addr_tbl[4] = 32'h10; addr_tbl[5] = 32'h14; addr_tbl[6] = 32'h108; addr_tbl[7] = 32'hFF;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state and single pulse latency.
    check("reset irq_o", 32'(irq_o), 0);
    check("reset irq_id_o", 32'(irq_id_o), 0);
    rd_chk("reset pending", 32'h00, 0);
    wr(32'h04, 32'h01);
    src = 8'h01; tick(); src = '0;
    rd_chk("pulse pending", 32'h00, 32'h01);
    check("model pending", m_pend, 32'h01);
    check("pulse irq not yet", 32'(irq_o), 0);
    tick();
    check("pulse irq", 32'(irq_o), 1);
    check("pulse irq_id", 32'(irq_id_o), 1);
    claim("claim src0", 1);
    wr(32'h0C, 1);

    // Priority, repeated claim, mismatched and matching complete.
    wr(32'h04, 32'hFF);
    src = 8'h0A; tick(); src = '0; tick();
    claim("claim prio", 2);
    rd_chk("pending after claim", 32'h00, 32'h08);
    claim("claim again", 2);
    wr(32'h0C, 4);
    check("bad complete irq", 32'(irq_o), 0);
    check("bad complete id", 32'(irq_id_o), 2);
    wr(32'h0C, 2);
    tick();
    check("next irq", 32'(irq_o), 1);
    check("next irq_id", 32'(irq_id_o), 4);
    claim("claim src3", 4);
    wr(32'h0C, 4);

    // Masked source pends, raises once enabled.
    wr(32'h04, 32'h00);
    src = 8'h20; tick(); src = '0; tick();
    rd_chk("masked pending", 32'h00, 32'h20);
    check("masked irq", 32'(irq_o), 0);
    wr(32'h04, 32'h20);
    tick();
    check("unmask irq", 32'(irq_o), 1);
    check("unmask irq_id", 32'(irq_id_o), 6);
    claim("claim src5", 6);
    wr(32'h0C, 6);

    // Set beats W1C on the same bit.
    src = 8'h04; tick(); src = '0; tick();
    src = 8'h04; req = 1'b1; we = 1'b1; addr = 32'h00; wdata = 32'h04;
    tick();
    src = '0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    rd_chk("set beats w1c", 32'h00, 32'h04);
    wr(32'h00, 32'h04);
    rd_chk("w1c clears", 32'h00, 0);

    // Held source: one event in edge mode, re-request in level mode.
    wr(32'h04, 32'h10);
    src = 8'h10; tick(); tick();
    check("held irq_id", 32'(irq_id_o), 5);
    claim("claim held", 5);
    wr(32'h0C, 5);
    tick();
    check("held re-request irq", 32'(irq_o), EdgeMode ? 0 : 1);
    check("held re-request id", 32'(irq_id_o), EdgeMode ? 0 : 5);
    repeat (5) tick();
    src = '0;
    rst = 1'b1; tick(); rst = 1'b0;

    // Reset during service.
    wr(32'h04, 32'hFF);
    src = 8'h81; tick(); src = '0; tick();
    claim("claim before reset", 1);
    src = 8'h01; tick(); src = '0; tick();
    rd_chk("pending in service", 32'h00, 32'h81);
    rst = 1'b1; tick(); rst = 1'b0;
    check("post-reset irq", 32'(irq_o), 0);
    check("post-reset id", 32'(irq_id_o), 0);
    rd_chk("post-reset claim", 32'h08, 0);
    rd_chk("post-reset pending", 32'h00, 0);
    rd_chk("post-reset enable", 32'h04, 0);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) src = NSRC'($urandom & $urandom);
      req  = $urandom_range(0, 1);
      we   = $urandom_range(0, 1);
      addr = addr_tbl[$urandom_range(0, 7)];
      if (addr[7:0] == 8'h0C && $urandom_range(0, 1)) wdata = m_svc;
      else if (addr[7:0] == 8'h0C) wdata = $urandom_range(0, NSRC + 1);
      else wdata = $urandom;
      tick();
    end
    rst = 1'b0; req = 1'b0; we = 1'b0; src = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intc.md
# intc

Single-level interrupt controller that sits directly downstream of the timer and other peripherals. It latches per-source interrupt requests into a pending register and masks them with an enable register. It arbitrates by fixed priority, lowest index wins, and presents one registered request plus source ID to the CPU. Software uses the same req/we/addr/wdata/rdata register bus as the timer, with a claim/complete handshake.

## Interface
- `DATA_WIDTH`, 32, register bus data width.
- `ADDR_WIDTH`, 32, register bus address width; only `addr_i[7:0]` is decoded, because the bus decoder strips the base.
- `NUM_SRC`, 8, number of interrupt sources, 1..31; source 0 maps to `timer_interrupt_o`.
- `clk_i` input 1: sole clock.
- `rst_i` input 1: synchronous, active-high reset.
- `req_i` input 1: bus access valid this cycle.
- `we_i` input 1: 1 = write, 0 = read.
- `addr_i` input `ADDR_WIDTH`: register byte address.
- `wdata_i` input `DATA_WIDTH`: write data.
- `rdata_o` output `DATA_WIDTH`: combinational read data; 0 when `req_i`=0 or the address is unmapped.
- `irq_src_i` input `NUM_SRC`: raw source requests; bit i belongs to source i.
- `irq_o` output 1: registered interrupt request to the CPU.
- `irq_id_o` output 5: registered ID (source index + 1) of the request or in-service source; 0 = none.

## Operation
- Register map:
  - 0x00 PENDING: read/write-1-to-clear.
  - 0x04 ENABLE: read/write, bits `[NUM_SRC-1:0]`.
  - 0x08 CLAIM: read with side effect.
  - 0x0C COMPLETE: write-only; reads return 0.
  - 0x10 RAW: read-only `irq_src_i`.
  - Unmapped offsets read 0 and ignore writes. Bits at or above `NUM_SRC` read 0.
- Pending set rule depends on `INTC_EDGE_EN` (see Configuration). Pending bits latch regardless of ENABLE.
- `best` = lowest i with `pending[i] & enable[i]`. `best_id` = i+1, or 0 if no such i.
- FSM state IDLE:
  - `irq_o` <= (`best_id`!=0) and `irq_id_o` <= `best_id`.
  - A CLAIM read (`req_i` & !`we_i` & addr 0x08) returns `best_id` on `rdata_o`.
  - If `best_id`!=0: clear `pending[best]`, store `svc_id`=`best_id`, and go to SERVICE.
  - A CLAIM read with `best_id`=0 returns 0 and stays in IDLE.
- FSM state SERVICE:
  - `irq_o` <= 0 and `irq_id_o` <= `svc_id`.
  - CLAIM reads return `svc_id` with no side effect.
  - A COMPLETE write with `wdata_i[4:0]`==`svc_id` returns to IDLE; a mismatched ID is ignored.
  - New sources keep latching into PENDING.
- Each cycle `req_i` is held counts as a separate access.
- Simultaneous events on the same bit resolve in this order: set beats W1C, and set beats claim-clear (a new request re-pends the bit).
- A COMPLETE write in IDLE is ignored.
- Writing ENABLE=0 during SERVICE does not abort service.

## Timing
- Reset (`rst_i` sampled high at a clock edge) values:
  - PENDING, ENABLE, RAW edge history, and `svc_id` = 0.
  - FSM = IDLE, `irq_o`=0, `irq_id_o`=0.
  - Reset mid-SERVICE discards the in-service ID.
- Source high sampled at edge N: pending bit set after edge N, and `irq_o`/`irq_id_o` update after edge N+1, i.e. 2-cycle latency.
- CLAIM read at edge N: `rdata_o` is valid in the same cycle (combinational), and state/pending update at edge N. `irq_o` falls after edge N+1.
- COMPLETE at edge N: state is IDLE after N, and the next pending request raises `irq_o` after edge N+1.
- Bus writes take effect at the clock edge; there are no wait states.

## Configuration
- `INTC_EDGE_EN` defined:
  - Edge mode: a per-source history flop is added, and `pending[i]` is set on `irq_src_i[i]` & !`prev[i]`.
  - A source held high raises exactly one pending event.
- `INTC_EDGE_EN` undefined:
  - Level mode: `pending[i]` is set every cycle `irq_src_i[i]`=1.
  - W1C or claim on a still-high source is re-set the next cycle.
  - No history flops are built.

## Test plan
- Reset, ENABLE=0x01, 1-cycle pulse on `irq_src_i[0]` -> PENDING=0x01 next cycle; `irq_o`=1 and `irq_id_o`=1 two cycles after the pulse.
- Sources 3 and 1 pending, ENABLE=0xFF, CLAIM read -> `rdata_o`=2 and PENDING=0x08. A second CLAIM read returns 2. COMPLETE write 4 is ignored, COMPLETE write 2 -> IDLE, then `irq_id_o`=4 after one more cycle.
- ENABLE=0x00 with source 5 pulsed -> PENDING=0x20 and `irq_o`=0. Write ENABLE=0x20 -> `irq_o`=1 and `irq_id_o`=6 two cycles later.
- Same-cycle W1C of bit 2 and a new edge on source 2 -> PENDING bit 2 stays 1.
- Edge mode, `irq_src_i[4]` held high 10 cycles, claim plus complete -> no second request. Level mode gives a second request with `irq_id_o`=5.
- `rst_i` asserted during SERVICE with PENDING=0x81 -> all registers 0, `irq_o`=0, and CLAIM reads 0 in the first cycle after reset.
